// File: rtl/control_recirculador.sv
// Lane recirculator control: steers the four probador lanes into the PCI datapath
// or back to the probador, latches FIFO thresholds and keeps sticky FIFO error flags.
module control_recirculador #(
  parameter int N_FIFO   = 8,
  parameter int UMBRAL_W = 3
) (
  input  logic                clk,
  input  logic                reset_L,
  input  logic                init,
  input  logic [UMBRAL_W-1:0] umbral_alto_in,
  input  logic [UMBRAL_W-1:0] umbral_bajo_in,
  input  logic [3:0]          validIn,
  input  logic [N_FIFO-1:0]   fifo_empty,
  input  logic [N_FIFO-1:0]   fifo_almost_full,
  input  logic [N_FIFO-1:0]   fifo_error,
  output logic                selector_IDLE,
  output logic [UMBRAL_W-1:0] umbral_alto,
  output logic [UMBRAL_W-1:0] umbral_bajo,
  output logic [4:0]          estado,
  output logic                idle_out,
  output logic                pausa,
  output logic [N_FIFO-1:0]   error_out,
  output logic [7:0]          count_recirc
);

  // One-hot encoding doubles as the externally visible estado value.
  typedef enum logic [4:0] {
    RESET  = 5'b00001,
    INIT   = 5'b00010,
    IDLE   = 5'b00100,
    ACTIVE = 5'b01000,
    ERROR  = 5'b10000
  } state_t;

  state_t              stateReg;
  state_t              stateNext;
  logic                quietReg;
  logic                pausaReg;
  logic [UMBRAL_W-1:0] umbralAltoReg;
  logic [UMBRAL_W-1:0] umbralBajoReg;
  logic [7:0]          countReg;
  logic                anyError;
  logic                anyValid;
  logic                allEmpty;
  logic                quietCycle;
  logic                selectorReg;

  assign anyError    = |fifo_error;
  assign anyValid    = |validIn;
  assign allEmpty    = &fifo_empty;
  assign quietCycle  = !anyValid && allEmpty;
  assign selectorReg = (stateReg == ACTIVE) && !pausaReg;

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      RESET: stateNext = INIT;
      ERROR: stateNext = ERROR;
      default: begin
        if (anyError) begin
          stateNext = ERROR;
        end else if (init) begin
          stateNext = INIT;
        end else begin
          case (stateReg)
            INIT: begin
              if (umbral_bajo_in < umbral_alto_in) stateNext = IDLE;
            end
            IDLE: begin
              if (anyValid || !allEmpty) stateNext = ACTIVE;
            end
            ACTIVE: begin
              // Second consecutive quiet cycle: the first one is remembered in quietReg.
              if (quietCycle && quietReg) stateNext = IDLE;
            end
            default: stateNext = stateReg;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      stateReg      <= RESET;
      quietReg      <= 1'b0;
      pausaReg      <= 1'b0;
      umbralAltoReg <= '0;
      umbralBajoReg <= '0;
      countReg      <= 8'd0;
    end else begin
      stateReg <= stateNext;
      quietReg <= (stateReg == ACTIVE) && (stateNext == ACTIVE) && quietCycle;
      // Back-pressure only exists while forwarding; any other state drops it.
      pausaReg <= (stateNext == ACTIVE) && (|fifo_almost_full);
      if (stateReg == INIT) begin
        umbralAltoReg <= umbral_alto_in;
        umbralBajoReg <= umbral_bajo_in;
      end
      if (stateNext == INIT) begin
        countReg <= 8'd0;
      end else if ((stateReg == ACTIVE) && !selectorReg && anyValid && (countReg != 8'hFF)) begin
        countReg <= countReg + 8'd1;
      end
    end
  end

  // Each FIFO error flag is sticky on its own until reset.
  generate
    for (genvar gi = 0; gi < N_FIFO; gi++) begin : gen_sticky
      logic stickyBit;
      always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
          stickyBit <= 1'b0;
        end else if (stateReg != RESET) begin
          stickyBit <= stickyBit | fifo_error[gi];
        end
      end
      assign error_out[gi] = stickyBit;
    end
  endgenerate

  assign estado        = stateReg;
  assign selector_IDLE = selectorReg;
  assign idle_out      = (stateReg == IDLE);
  assign pausa         = pausaReg;
  assign umbral_alto   = umbralAltoReg;
  assign umbral_bajo   = umbralBajoReg;
  assign count_recirc  = countReg;

endmodule

// File: tb/tb_control_recirculador.sv
// Directed bench for control_recirculador: behavioural model checked every cycle
// plus literal expectations at the key points of each scenario.
module tb_control_recirculador;
  localparam int NF = 8;
  localparam int UW = 3;

  logic          clk = 1'b0;
  logic          reset_L = 1'b0;
  logic          init = 1'b1;
  logic [UW-1:0] altoIn = 3'd6;
  logic [UW-1:0] bajoIn = 3'd2;
  logic [3:0]    validIn = 4'd0;
  logic [NF-1:0] fifoEmpty = '1;
  logic [NF-1:0] almostFull = '0;
  logic [NF-1:0] fifoError = '0;

  logic          selector;
  logic [UW-1:0] umbralAlto;
  logic [UW-1:0] umbralBajo;
  logic [4:0]    estado;
  logic          idleOut;
  logic          pausa;
  logic [NF-1:0] errorOut;
  logic [7:0]    countRecirc;

  int vectors = 0;
  int miscompares = 0;
  bit checkEn = 1'b0;

  control_recirculador #(.N_FIFO(NF), .UMBRAL_W(UW)) dut (
    .clk(clk), .reset_L(reset_L), .init(init),
    .umbral_alto_in(altoIn), .umbral_bajo_in(bajoIn),
    .validIn(validIn), .fifo_empty(fifoEmpty),
    .fifo_almost_full(almostFull), .fifo_error(fifoError),
    .selector_IDLE(selector), .umbral_alto(umbralAlto), .umbral_bajo(umbralBajo),
    .estado(estado), .idle_out(idleOut), .pausa(pausa),
    .error_out(errorOut), .count_recirc(countRecirc)
  );

  always #5 clk = ~clk;

  // Model: state as an index 0..4 (RESET, INIT, IDLE, ACTIVE, ERROR)
  localparam int M_RESET = 0, M_INIT = 1, M_IDLE = 2, M_ACTIVE = 3, M_ERROR = 4;
  int            mState = M_RESET;
  int            mQuietRun = 0;
  bit            mPausa = 1'b0;
  int            mAlto = 0;
  int            mBajo = 0;
  logic [NF-1:0] mErr = '0;
  int            mCount = 0;

  always @(posedge clk or negedge reset_L) begin
    int  ns;
    bit  quiet;
    bit  steering;
    if (!reset_L) begin
      mState <= M_RESET; mQuietRun <= 0; mPausa <= 1'b0;
      mAlto <= 0; mBajo <= 0; mErr <= '0; mCount <= 0;
    end else begin
      quiet    = (validIn == 4'd0) && (fifoEmpty == '1);
      steering = (mState == M_ACTIVE) && !mPausa;
      ns = mState;
      if (mState == M_RESET) ns = M_INIT;
      else if (mState == M_ERROR) ns = M_ERROR;
      else if (fifoError != '0) ns = M_ERROR;
      else if (init) ns = M_INIT;
      else if (mState == M_INIT && int'(bajoIn) < int'(altoIn)) ns = M_IDLE;
      else if (mState == M_IDLE && (validIn != 4'd0 || fifoEmpty != '1)) ns = M_ACTIVE;
      else if (mState == M_ACTIVE && quiet && mQuietRun + 1 >= 2) ns = M_IDLE;
      mQuietRun <= (mState == M_ACTIVE && ns == M_ACTIVE && quiet) ? mQuietRun + 1 : 0;
      mPausa <= (ns == M_ACTIVE) && (almostFull != '0);
      if (mState == M_INIT) begin
        mAlto <= int'(altoIn);
        mBajo <= int'(bajoIn);
      end
      if (mState != M_RESET) mErr <= mErr | fifoError;
      if (ns == M_INIT) mCount <= 0;
      else if (mState == M_ACTIVE && !steering && validIn != 4'd0)
        mCount <= (mCount + 1 > 255) ? 255 : mCount + 1;
      mState <= ns;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      check("m_estado", int'(estado), 1 << mState);
      check("m_selector", int'(selector), int'(mState == M_ACTIVE && !mPausa));
      check("m_idle_out", int'(idleOut), int'(mState == M_IDLE));
      check("m_pausa", int'(pausa), int'(mPausa));
      check("m_alto", int'(umbralAlto), mAlto);
      check("m_bajo", int'(umbralBajo), mBajo);
      check("m_error_out", int'(errorOut), int'(mErr));
      check("m_count", int'(countRecirc), mCount);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    cycles(2);
    checkEn = 1'b1;
    check("reset_estado", int'(estado), 1);
    check("reset_selector", int'(selector), 0);
    $display("reset held: estado=%b", estado);

    // Reset release with init held, then thresholds 6/2 accepted
    reset_L = 1'b1;
    cycles(1);
    check("init_entry", int'(estado), 2);
    cycles(2);
    init = 1'b0;
    cycles(1);
    check("init_to_idle", int'(estado), 4);
    check("alto_6", int'(umbralAlto), 6);
    check("bajo_2", int'(umbralBajo), 2);
    check("idle_selector", int'(selector), 0);
    $display("init 6/2 -> estado=%b alto=%0d bajo=%0d", estado, umbralAlto, umbralBajo);

    // Invalid thresholds keep INIT
    init = 1'b1; altoIn = 3'd2; bajoIn = 3'd5;
    cycles(1);
    init = 1'b0;
    cycles(3);
    check("bad_umbral_stay", int'(estado), 2);
    check("bad_umbral_alto", int'(umbralAlto), 2);
    altoIn = 3'd6; bajoIn = 3'd2;
    cycles(1);
    check("good_umbral_idle", int'(estado), 4);
    $display("init 2/5 held in INIT, then 6/2 -> estado=%b", estado);

    // Busy run then two quiet cycles
    validIn = 4'b0001;
    cycles(1);
    check("active_entry", int'(estado), 8);
    check("active_selector", int'(selector), 1);
    cycles(3);
    validIn = 4'b0000;
    cycles(1);
    check("one_quiet_stays", int'(estado), 8);
    cycles(1);
    check("two_quiet_idle", int'(estado), 4);
    check("two_quiet_sel", int'(selector), 0);
    $display("busy run + quiet -> estado=%b", estado);

    // Back-pressure for 3 cycles
    validIn = 4'b1111;
    cycles(1);
    almostFull = 8'b0000_0100;
    cycles(1);
    check("bp_pausa", int'(pausa), 1);
    check("bp_selector", int'(selector), 0);
    cycles(2);
    almostFull = '0;
    cycles(1);
    check("bp_count3", int'(countRecirc), 3);
    check("bp_recover_pausa", int'(pausa), 0);
    check("bp_recover_sel", int'(selector), 1);
    $display("back-pressure x3 -> count=%0d pausa=%b", countRecirc, pausa);

    // Saturation of the recirculation counter
    almostFull = 8'b1000_0000;
    cycles(300);
    check("sat_255", int'(countRecirc), 255);
    almostFull = '0;
    init = 1'b1;
    cycles(1);
    check("sat_init", int'(estado), 2);
    check("sat_clear", int'(countRecirc), 0);
    init = 1'b0; validIn = 4'd0;
    cycles(1);
    $display("saturation then init -> estado=%b count=%0d", estado, countRecirc);

    // Error beats init, ERROR absorbing, async reset mid-cycle
    validIn = 4'b1111;
    cycles(1);
    fifoError = 8'b0010_0000; init = 1'b1;
    cycles(1);
    fifoError = '0;
    check("err_state", int'(estado), 16);
    check("err_out", int'(errorOut), 32);
    check("err_selector", int'(selector), 0);
    cycles(3);
    check("err_absorbing", int'(estado), 16);
    #1 reset_L = 1'b0;
    #1;
    check("async_estado", int'(estado), 1);
    check("async_err", int'(errorOut), 0);
    check("async_alto", int'(umbralAlto), 0);
    check("async_selector", int'(selector), 0);
    $display("error + async reset -> estado=%b error_out=%b", estado, errorOut);
    init = 1'b0; validIn = 4'd0;
    cycles(1);
    reset_L = 1'b1;
    cycles(1);
    check("rerelease_init", int'(estado), 2);
    cycles(1);
    check("rerelease_idle", int'(estado), 4);
    $display("reset release -> estado=%b", estado);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
